// File: rtl/psum_writeback.sv
// psum_writeback: write-back stage for the final-add unit.
// Captures one 64-bit double per output pixel (cur_state==7, wait_ctr==12),
// can clamp negative values to +0.0, buffers them in a DEPTH-entry FIFO and
// writes them to the global buffer at base_addr, base_addr+1, ... using a
// valid/ready handshake. A start/done pair frames each batch.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle launch pulse (only honoured in IDLE)
//   base_addr           GB address of the first output
//   num_outputs         outputs in the batch (0 = none)
//   cur_state, wait_ctr controller state / wait counter (capture timing)
//   add_result          double from the final adder
//   gb_we/addr/wdata    GB write request (valid) and head-of-FIFO payload
//   gb_ready            GB accepts the write this cycle
//   busy                batch in progress (stays up through the done cycle)
//   done                one-cycle pulse once every result is written
//   overflow            sticky: a capture was dropped on a full FIFO
module psum_writeback #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4,
  parameter int RELU_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_outputs,
  input  logic [3:0]        cur_state,
  input  logic [4:0]        wait_ctr,
  input  logic [63:0]       add_result,
  output logic              gb_we,
  output logic [ADDR_W-1:0] gb_addr,
  output logic [63:0]       gb_wdata,
  input  logic              gb_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } ent_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q, num_q, cap_cnt, cnt_nx;
  ent_t              mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              cap, pop, full, empty, push_ok;
  ent_t              cap_ent;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign cap     = (state == RUN) && (cur_state == 4'd7) && (wait_ctr == 5'd12);
  assign pop     = !empty && gb_ready;
  // A full FIFO still takes the sample if the head leaves the same cycle.
  assign push_ok = cap && (!full || pop);
  assign cnt_nx  = cap_cnt + 1'b1;

  // Sign bit alone decides the clamp, so -0.0 and negative NaN become +0.0.
  assign cap_ent.addr = base_q + cap_cnt;
  assign cap_ent.data = ((RELU_EN != 0) && add_result[63]) ? 64'h0 : add_result;

  // Payload is forced to zero while nothing is pending so idle outputs stay quiet.
  assign gb_we    = !empty;
  assign gb_addr  = empty ? '0 : mem[rd_ptr].addr;
  assign gb_wdata = empty ? '0 : mem[rd_ptr].data;

  // Storage needs no reset: it is only observed through a non-empty FIFO.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cap_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      num_q    <= '0;
      cap_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      // Covers the DONE cycle too, so busy overlaps the done pulse.
      busy <= (state != IDLE) || start;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;

      case (state)
        IDLE: if (start) begin
          base_q   <= base_addr;
          num_q    <= num_outputs;
          cap_cnt  <= '0;
          overflow <= 1'b0;
          state    <= (num_outputs == '0) ? DONE : RUN;
        end
        RUN: if (cap) begin
          // Dropped samples still consume an address slot.
          if (!push_ok) overflow <= 1'b1;
          cap_cnt <= cnt_nx;
          if (cnt_nx == num_q) state <= FLUSH;
        end
        FLUSH: if (empty) state <= DONE;
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
module tb_psum_writeback;
  localparam int AW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0, num_outputs = '0;
  logic [3:0]    cur_state = '0;
  logic [4:0]    wait_ctr = '0;
  logic [63:0]   add_result = '0;
  logic          gb_ready = 1'b0;

  logic          we0, we1, busy0, busy1, done0, done1, ovf0, ovf1;
  logic [AW-1:0] a0, a1;
  logic [63:0]   d0, d1;

  always #5 clk = ~clk;

  psum_writeback #(.ADDR_W(AW), .DEPTH(D), .RELU_EN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_outputs(num_outputs), .cur_state(cur_state), .wait_ctr(wait_ctr),
    .add_result(add_result), .gb_we(we0), .gb_addr(a0), .gb_wdata(d0),
    .gb_ready(gb_ready), .busy(busy0), .done(done0), .overflow(ovf0));

  psum_writeback #(.ADDR_W(AW), .DEPTH(D), .RELU_EN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_outputs(num_outputs), .cur_state(cur_state), .wait_ctr(wait_ctr),
    .add_result(add_result), .gb_we(we1), .gb_addr(a1), .gb_wdata(d1),
    .gb_ready(gb_ready), .busy(busy1), .done(done1), .overflow(ovf1));

  int total = 0;
  int bad   = 0;

  // ---------------- reference model (queue of pending GB writes) ----------
  typedef struct {
    logic [AW-1:0] a;
    logic [63:0]   d;
  } ent_t;

  ent_t          q[$];
  int            m_ph;     // 0 idle, 1 capturing, 2 draining, 3 finishing
  int            m_cnt;
  logic [AW-1:0] m_base, m_num;
  logic          m_done, m_busy, m_ovf;

  function automatic logic [63:0] relu(input logic [63:0] v);
    return v[63] ? 64'h0 : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ph = 0; m_cnt = 0; m_base = '0; m_num = '0;
    m_done = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
  endtask

  // Called right after a rising edge, with the inputs that edge sampled.
  task automatic model_edge();
    bit   pop, cap, full, emp;
    int   oph;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    emp  = (q.size() == 0);
    full = (q.size() == D);
    pop  = !emp && gb_ready;
    cap  = (m_ph == 1) && (cur_state == 4'd7) && (wait_ctr == 5'd12);
    oph  = m_ph;
    if (pop) void'(q.pop_front());
    case (oph)
      0: if (start) begin
        m_base = base_addr; m_num = num_outputs; m_cnt = 0; m_ovf = 1'b0;
        m_ph = (num_outputs == 0) ? 3 : 1;
      end
      1: if (cap) begin
        e.a = m_base + AW'(m_cnt);
        e.d = add_result;
        if (!full || pop) q.push_back(e);
        else m_ovf = 1'b1;
        m_cnt++;
        if (m_cnt == int'(m_num)) m_ph = 2;
      end
      2: if (emp) m_ph = 3;
      default: m_ph = 0;
    endcase
    m_done = (oph == 3);
    m_busy = (m_ph != 0) || (oph == 3);
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic          ewe;
    logic [AW-1:0] ea;
    logic [63:0]   ed;
    ewe = (q.size() > 0);
    ea  = ewe ? q[0].a : '0;
    ed  = ewe ? q[0].d : '0;
    chk("we",    we0,   ewe);  chk("we_r",    we1,   ewe);
    chk("addr",  a0,    ea);   chk("addr_r",  a1,    ea);
    chk("wdata", d0,    ed);   chk("wdata_r", d1,    relu(ed));
    chk("busy",  busy0, m_busy); chk("busy_r", busy1, m_busy);
    chk("done",  done0, m_done); chk("done_r", done1, m_done);
    chk("ovf",   ovf0,  m_ovf);  chk("ovf_r",  ovf1,  m_ovf);
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 ns later.
  task automatic cyc(input bit st, input logic [AW-1:0] b, input logic [AW-1:0] n,
                     input logic [3:0] cs, input logic [4:0] wc,
                     input logic [63:0] ar, input bit rdy);
    start = st; base_addr = b; num_outputs = n; cur_state = cs;
    wait_ctr = wc; add_result = ar; gb_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 4'd0, 5'd0, 64'h0, rdy);
  endtask

  task automatic capt(input logic [63:0] v, input bit rdy);
    cyc(0, '0, '0, 4'd7, 5'd12, v, rdy);
  endtask

  // ---------------- vector table for the basic batch ----------------------
  typedef struct {
    bit            st;
    logic [AW-1:0] base, num;
    logic [3:0]    cs;
    logic [4:0]    wc;
    logic [63:0]   ar;
    bit            rdy;
    bit            e_we;
    logic [AW-1:0] e_a;
    logic [63:0]   e_d, e_dr;
    bit            e_busy, e_done;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 16'h0100, 16'd3, 4'd0, 5'd0,  64'h0,                1, 0, 16'h0,    64'h0,                64'h0,                1, 0};
    tbl[1] = '{0, 16'h0,    16'd0, 4'd7, 5'd12, 64'h3FF0000000000000, 1, 1, 16'h0100, 64'h3FF0000000000000, 64'h3FF0000000000000, 1, 0};
    tbl[2] = '{0, 16'h0,    16'd0, 4'd7, 5'd12, 64'h4000000000000000, 1, 1, 16'h0101, 64'h4000000000000000, 64'h4000000000000000, 1, 0};
    tbl[3] = '{0, 16'h0,    16'd0, 4'd7, 5'd12, 64'hC004000000000000, 1, 1, 16'h0102, 64'hC004000000000000, 64'h0,                1, 0};
    tbl[4] = '{0, 16'h0,    16'd0, 4'd0, 5'd0,  64'h0,                1, 0, 16'h0,    64'h0,                64'h0,                1, 0};
    tbl[5] = '{0, 16'h0,    16'd0, 4'd0, 5'd0,  64'h0,                1, 0, 16'h0,    64'h0,                64'h0,                1, 0};
    tbl[6] = '{0, 16'h0,    16'd0, 4'd0, 5'd0,  64'h0,                1, 0, 16'h0,    64'h0,                64'h0,                1, 1};
    tbl[7] = '{0, 16'h0,    16'd0, 4'd0, 5'd0,  64'h0,                1, 0, 16'h0,    64'h0,                64'h0,                0, 0};

    model_reset();
    idle(2, 1'b0);
    rst = 1'b0;
    idle(1, 1'b0);
    chk("rst_we", we0, 1'b0); chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0); chk("rst_ovf", ovf0, 1'b0);

    // Basic batch with hand-derived expectations.
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].st, tbl[i].base, tbl[i].num, tbl[i].cs, tbl[i].wc, tbl[i].ar, tbl[i].rdy);
      chk($sformatf("tbl%0d_we", i),    we0,   tbl[i].e_we);
      chk($sformatf("tbl%0d_addr", i),  a0,    tbl[i].e_a);
      chk($sformatf("tbl%0d_wdata", i), d0,    tbl[i].e_d);
      chk($sformatf("tbl%0d_relu", i),  d1,    tbl[i].e_dr);
      chk($sformatf("tbl%0d_busy", i),  busy0, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i),  done0, tbl[i].e_done);
      chk($sformatf("tbl%0d_ovf", i),   ovf0,  1'b0);
    end

    // ReLU patterns (-2.5, -0.0, 3.0) checked on both instances by the model.
    cyc(1, 16'h0200, 16'd3, 4'd0, 5'd0, 64'h0, 1);
    capt(64'hC004000000000000, 1);
    chk("relu_neg", d1, 64'h0);
    capt(64'h8000000000000000, 1);
    chk("relu_negzero", d1, 64'h0);
    capt(64'h4008000000000000, 1);
    chk("relu_pos", d1, 64'h4008000000000000);
    idle(5, 1);

    // Zero-length batch: done two edges after start, never a write.
    cyc(1, 16'h0300, 16'd0, 4'd0, 5'd0, 64'h0, 1);
    idle(1, 1);
    chk("zero_done", done0, 1'b1);
    idle(2, 1);

    // start while busy is ignored; non-matching capture conditions ignored.
    cyc(1, 16'h0400, 16'd2, 4'd0, 5'd0, 64'h0, 1);
    cyc(1, 16'h0900, 16'd5, 4'd7, 5'd11, 64'h1111, 1);
    cyc(0, '0, '0, 4'd6, 5'd12, 64'h2222, 1);
    chk("nocap_we", we0, 1'b0);
    capt(64'h3333, 1);
    chk("busy_start_addr", a0, 16'h0400);
    capt(64'h4444, 1);
    idle(5, 1);

    // Address wrap.
    cyc(1, 16'hFFFE, 16'd3, 4'd0, 5'd0, 64'h0, 1);
    capt(64'hA, 1); capt(64'hB, 1); capt(64'hC, 1);
    chk("wrap_addr", a0, 16'h0000);
    idle(5, 1);

    // Backpressure: fifth capture dropped, then drain in order.
    cyc(1, 16'h0500, 16'd5, 4'd0, 5'd0, 64'h0, 0);
    for (int i = 0; i < 5; i++) capt(64'h100 + 64'(i), 0);
    chk("bp_ovf", ovf0, 1'b1);
    idle(2, 0);
    chk("bp_flush_busy", busy0, 1'b1);
    idle(8, 1);

    // Full FIFO plus capture coincident with a pop: accepted, no overflow.
    cyc(1, 16'h0600, 16'd5, 4'd0, 5'd0, 64'h0, 0);
    for (int i = 0; i < 4; i++) capt(64'h200 + 64'(i), 0);
    capt(64'h204, 1);
    chk("coinc_ovf", ovf0, 1'b0);
    idle(8, 1);

    // Reset with two entries buffered.
    cyc(1, 16'h0700, 16'd4, 4'd0, 5'd0, 64'h0, 0);
    capt(64'h301, 0); capt(64'h302, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_we", we0, 1'b0); chk("mid_rst_addr", a0, '0);
    chk("mid_rst_wdata", d0, 64'h0); chk("mid_rst_busy", busy0, 1'b0);
    idle(1, 1);
    rst = 1'b0;
    idle(3, 1);
    cyc(1, 16'h0800, 16'd2, 4'd0, 5'd0, 64'h0, 1);
    capt(64'h401, 1); capt(64'h402, 1);
    idle(5, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 7) == 0), AW'($urandom), AW'($urandom_range(0, 6)),
          ($urandom_range(0, 1) == 1) ? 4'd7 : 4'($urandom_range(0, 15)),
          5'($urandom_range(10, 13)), {$urandom, $urandom},
          ($urandom_range(0, 3) != 0));
    end
    idle(20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_writeback.md
# psum_writeback

Downstream write-back stage for the final-add unit: captures the 64-bit double-precision partial sum it produces once per output pixel, applies optional ReLU, buffers it in a small FIFO, and writes it to the global buffer (GB) with a valid/ready handshake and auto-incrementing address. A per-layer start/done pair lets the controller launch a batch of N outputs and learn when every result has been committed to GB.

## Interface
Parameters:
- ADDR_W, 16, GB word-address width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RELU_EN, 0, 1 = clamp negative results to +0.0

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; loads base_addr/num_outputs, honoured only in IDLE
- base_addr  in  ADDR_W  GB address of first output
- num_outputs  in  ADDR_W  outputs in this batch; 0 means none
- cur_state  in  4  controller state
- wait_ctr  in  5  controller wait counter
- add_result  in  64  IEEE-754 double from the final-add stage
- gb_we  out  1  write request, valid
- gb_addr  out  ADDR_W  write address
- gb_wdata  out  64  write data
- gb_ready  in  1  GB accepts the write this cycle
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when batch fully written
- overflow  out  1  sticky: a capture was dropped because the FIFO was full

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: start → load base_addr, num_outputs; clear cap_cnt, overflow. Go to RUN, or to DONE if num_outputs==0.
- RUN: capture when cur_state==7 && wait_ctr==12, i.e. the cycle after the final adder registers add_result (wait_ctr 11). Each capture:
  - data = (RELU_EN && add_result[63]) ? 64'h0 : add_result (−0.0 and negative NaN also become +0.0);
  - addr = base_addr + cap_cnt (mod 2^ADDR_W, wraps silently);
  - cap_cnt++; when cap_cnt reaches num_outputs → FLUSH.
- Extra capture conditions in FLUSH/DONE/IDLE are ignored.
- FLUSH: no captures; when FIFO empty → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- start outside IDLE ignored.
- FIFO: push = capture; pop = gb_we && gb_ready. Push into a full FIFO is accepted if a pop happens the same cycle. Otherwise the sample is dropped, overflow set (sticky until next accepted start), and cap_cnt still increments so later addresses stay aligned.
- gb_we = FIFO non-empty; gb_addr/gb_wdata = head entry, held stable while gb_we && !gb_ready.

## Timing
- Reset values: gb_we=0, gb_addr=0, gb_wdata=0, busy=0, done=0, overflow=0; FIFO empty, state IDLE, cap_cnt=0. Reset mid-batch discards all buffered entries; no further writes.
- start sampled at edge t; busy=1 from t+1.
- Capture at edge c (wait_ctr==12); gb_we=1 with that entry from c+1 if FIFO was empty. With gb_ready high, a write completes at edge c+1.
- Throughput: one write per cycle when gb_ready held high.
- FIFO occupancy 0..DEPTH; pointers wrap modulo DEPTH.
- done asserts the cycle after the state enters DONE, which is one edge after the last pop leaves the FIFO empty. busy is still 1 during done and falls the next cycle.
- num_outputs==0: done pulses at t+2 after start (IDLE→DONE→IDLE), no gb_we.

## Test plan
- Basic: start, base_addr=0x0100, num_outputs=3; three captures with add_result 64'h3FF0000000000000, 64'h4000000000000000, 64'hC004000000000000; gb_ready=1 → writes (0x0100,1.0), (0x0101,2.0), (0x0102,−2.5) each one cycle after capture; single done pulse; overflow=0.
- ReLU (RELU_EN=1): captures −2.5, 64'h8000000000000000, 3.0 → wdata 0, 0, 64'h4008000000000000.
- Backpressure: DEPTH=4, gb_ready=0, five captures → first four buffered, fifth dropped, overflow=1. Release gb_ready → addresses base+0..base+3 written in order, state holds FLUSH until empty, then done. Also: with FIFO full, a capture coincident with a pop is accepted, no overflow.
- Wrap: base_addr=0xFFFE, num_outputs=3 → addresses 0xFFFE, 0xFFFF, 0x0000.
- Protocol edges: num_outputs=0 → done at t+2, no gb_we. start while busy ignored. Capture condition with wait_ctr≠12 or cur_state≠7 → no write.
- Reset mid-batch: assert rst with 2 entries buffered → gb_we drops immediately, all outputs at reset values, no done. Next start runs cleanly.
